// File: rtl/snake_pkg.sv
// snake_pkg: shared definitions for the snake grid scheduler.
//   - cell codes stored in the 2-bit grid RAM
//   - key-controller mode and forward codes
//   - scheduler FSM state encoding
//   - width helpers and the 16-bit food LFSR step
package snake_pkg;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'd0,
    CELL_BODY  = 2'd1,
    CELL_FOOD  = 2'd2,
    CELL_RSVD  = 2'd3
  } cell_t;

  localparam logic [3:0] MODE_RESET_SNAKE = 4'd0;
  localparam logic [3:0] MODE_UPDATE_POS  = 4'd1;

  // X_UP: x+1, X_DOWN: x-1, Y_UP: y-1, Y_DOWN: y+1
  typedef enum logic [1:0] {
    X_UP   = 2'b00,
    X_DOWN = 2'b01,
    Y_UP   = 2'b10,
    Y_DOWN = 2'b11
  } fwd_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CLR,
    ST_INIT,
    ST_HEAD_RD,
    ST_HEAD_CHK,
    ST_HEAD_WR,
    ST_TAIL_CLR,
    ST_FOOD_RD,
    ST_FOOD_CHK,
    ST_FOOD_WR
  } state_t;

  function automatic int coord_w(input int cells);
    return $clog2(cells);
  endfunction

  function automatic int addr_w(input int w, input int h);
    return $clog2(w * h);
  endfunction

  // Fibonacci LFSR, taps 16,14,13,11
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/snake_pos_fifo.sv
// snake_pos_fifo: circular FIFO of snake body cell addresses, oldest entry = tail.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   clr         restart the FIFO; a push in the same cycle becomes the only entry
//   push, din   append a new head address
//   pop         drop the tail entry (push+pop together keeps the count)
//   tail        current tail address (combinational)
//   count       number of stored entries, 0..DEPTH
module snake_pos_fifo #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         tail,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clr) begin
      rptr  <= '0;
      wptr  <= push ? PW'(1) : '0;
      count <= push ? (PW+1)'(1) : '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[clr ? '0 : wptr] <= din;
  end

  assign tail = mem[rptr];

endmodule

// File: rtl/snake_grid_sched.sv
// snake_grid_sched: sequences every game-state access to the single-port
// snake grid RAM (2 bits per cell, address = y*GRID_W + x).
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   en, mode, forward      game tick from key controller (mode 0 reset, 1 update)
//   disp_req, disp_addr    display read request; always wins the RAM port
//   disp_valid, disp_rdata display read data, one cycle after disp_req
//   ram_ce/we/addr/wdata   RAM port
//   ram_rdata              RAM read data, one cycle after a read
//   busy                   sequence in progress
//   dead                   collision seen, held until the next snake reset
//   length, score          snake length, food eaten since reset
// Build option: define WALL_DEATH_EN to make leaving the grid fatal
// instead of wrapping the coordinates.
module snake_grid_sched
  import snake_pkg::*;
#(
  parameter int  GRID_W     = 32,
  parameter int  GRID_H     = 32,
  parameter int  MAX_LEN    = 64,
  parameter int  FOOD_TRIES = 8,
  localparam int ADDR_W     = addr_w(GRID_W, GRID_H)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [3:0]        mode,
  input  logic [1:0]        forward,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_valid,
  output logic [1:0]        disp_rdata,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [1:0]        ram_wdata,
  input  logic [1:0]        ram_rdata,
  output logic              busy,
  output logic              dead,
  output logic [6:0]        length,
  output logic [15:0]       score
);

  localparam int XW = coord_w(GRID_W);
  localparam int YW = coord_w(GRID_H);
  localparam int LW = $clog2(MAX_LEN) + 1;
  localparam int TW = $clog2(FOOD_TRIES) + 1;
  localparam logic [XW-1:0]     CX        = XW'(GRID_W / 2);
  localparam logic [YW-1:0]     CY        = YW'(GRID_H / 2);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(GRID_W * GRID_H - 1);
  localparam logic [LW-1:0]     LEN_MAX   = LW'(MAX_LEN);
  localparam logic [TW-1:0]     TRY_LAST  = TW'(FOOD_TRIES - 1);

  state_t state, state_nxt;

  logic [XW-1:0]     head_x, next_x, step_x;
  logic [YW-1:0]     head_y, next_y, step_y;
  logic [1:0]        dir;
  logic [ADDR_W-1:0] clr_addr, food_addr, tail_addr, fifo_tail, fifo_din;
  logic [LW-1:0]     fifo_count;
  logic [TW-1:0]     tries;
  logic [15:0]       lfsr;
  logic              eat, rd_pend, wall_hit, free;
  logic [1:0]        cell_q, cell_cur;
  logic              fifo_push, fifo_pop, fifo_clr;
  logic              fsm_ce, fsm_we;
  logic [ADDR_W-1:0] fsm_addr;
  logic [1:0]        fsm_wdata;

  assign free = !disp_req;

  // A read result is only on ram_rdata in the cycle right after the read;
  // keep a copy so a check state stalled by the display still sees it.
  assign cell_cur = rd_pend ? ram_rdata : cell_q;

  always_comb begin
    step_x = head_x;
    step_y = head_y;
    case (dir)
      X_UP:    step_x = head_x + 1'b1;
      X_DOWN:  step_x = head_x - 1'b1;
      Y_UP:    step_y = head_y - 1'b1;
      default: step_y = head_y + 1'b1;
    endcase
  end

`ifdef WALL_DEATH_EN
  always_comb begin
    case (dir)
      X_UP:    wall_hit = &head_x;
      X_DOWN:  wall_hit = ~|head_x;
      Y_UP:    wall_hit = ~|head_y;
      default: wall_hit = &head_y;
    endcase
  end
`else
  assign wall_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    fsm_ce    = 1'b0;
    fsm_we    = 1'b0;
    fsm_addr  = '0;
    fsm_wdata = CELL_EMPTY;
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;
    fifo_clr  = 1'b0;
    fifo_din  = {next_y, next_x};
    case (state)
      ST_IDLE: begin
        if (en && mode == MODE_RESET_SNAKE)                state_nxt = ST_CLR;
        else if (en && mode == MODE_UPDATE_POS && !dead)   state_nxt = ST_HEAD_RD;
      end
      ST_CLR: begin
        fsm_ce   = 1'b1;
        fsm_we   = 1'b1;
        fsm_addr = clr_addr;
        if (free && clr_addr == LAST_ADDR) state_nxt = ST_INIT;
      end
      ST_INIT: begin
        fsm_ce    = 1'b1;
        fsm_we    = 1'b1;
        fsm_addr  = {CY, CX};
        fsm_wdata = CELL_BODY;
        fifo_din  = {CY, CX};
        if (free) begin
          fifo_clr  = 1'b1;
          fifo_push = 1'b1;
          state_nxt = ST_FOOD_RD;
        end
      end
      ST_HEAD_RD: begin
        fsm_ce   = !wall_hit;
        fsm_addr = {step_y, step_x};
        if (free) state_nxt = wall_hit ? ST_IDLE : ST_HEAD_CHK;
      end
      ST_HEAD_CHK: begin
        if (free) state_nxt = (cell_cur == CELL_BODY || cell_cur == CELL_RSVD) ? ST_IDLE : ST_HEAD_WR;
      end
      ST_HEAD_WR: begin
        fsm_ce    = 1'b1;
        fsm_we    = 1'b1;
        fsm_addr  = {next_y, next_x};
        fsm_wdata = CELL_BODY;
        if (free) begin
          fifo_push = 1'b1;
          // The tail leaves the FIFO here, in step with the head push, so a
          // full FIFO never overflows; its address is kept for TAIL_CLR.
          fifo_pop  = !eat || fifo_count == LEN_MAX;
          state_nxt = (eat && fifo_count != LEN_MAX) ? ST_FOOD_RD : ST_TAIL_CLR;
        end
      end
      ST_TAIL_CLR: begin
        fsm_ce   = 1'b1;
        fsm_we   = 1'b1;
        fsm_addr = tail_addr;
        if (free) state_nxt = eat ? ST_FOOD_RD : ST_IDLE;
      end
      ST_FOOD_RD: begin
        fsm_ce   = 1'b1;
        fsm_addr = lfsr[ADDR_W-1:0];
        if (free) state_nxt = ST_FOOD_CHK;
      end
      ST_FOOD_CHK: begin
        if (free) begin
          if (cell_cur == CELL_EMPTY) state_nxt = ST_FOOD_WR;
          else if (tries == TRY_LAST) state_nxt = ST_IDLE;
          else                        state_nxt = ST_FOOD_RD;
        end
      end
      ST_FOOD_WR: begin
        fsm_ce    = 1'b1;
        fsm_we    = 1'b1;
        fsm_addr  = food_addr;
        fsm_wdata = CELL_FOOD;
        if (free) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // A snake reset tick restarts the whole sequence from any state.
    if (en && mode == MODE_RESET_SNAKE) state_nxt = ST_CLR;
  end

  assign ram_ce     = disp_req | fsm_ce;
  assign ram_we     = free & fsm_we;
  assign ram_addr   = disp_req ? disp_addr : fsm_addr;
  assign ram_wdata  = disp_req ? 2'b00 : fsm_wdata;
  assign disp_rdata = ram_rdata;
  assign busy       = (state != ST_IDLE);
  assign length     = 7'(fifo_count);

  // control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      lfsr       <= 16'hACE1;
      head_x     <= CX;
      head_y     <= CY;
      dir        <= 2'b00;
      dead       <= 1'b0;
      score      <= '0;
      eat        <= 1'b0;
      tries      <= '0;
      clr_addr   <= '0;
      rd_pend    <= 1'b0;
      disp_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      disp_valid <= disp_req;
      rd_pend    <= free && fsm_ce && !fsm_we;
      if (state == ST_FOOD_CHK && free && cell_cur != CELL_EMPTY) lfsr <= lfsr_step(lfsr_step(lfsr));
      else                                                        lfsr <= lfsr_step(lfsr);
      if (en && mode == MODE_RESET_SNAKE) clr_addr <= '0;
      else if (state == ST_CLR && free)   clr_addr <= clr_addr + 1'b1;
      if (state == ST_IDLE && en) dir <= forward;
      if (state != ST_FOOD_RD && state != ST_FOOD_CHK) tries <= '0;
      if (free) begin
        case (state)
          ST_INIT: begin
            head_x <= CX;
            head_y <= CY;
            score  <= '0;
            dead   <= 1'b0;
          end
          ST_HEAD_RD:  if (wall_hit) dead <= 1'b1;
          ST_HEAD_CHK: begin
            if (cell_cur == CELL_BODY || cell_cur == CELL_RSVD) dead <= 1'b1;
            eat <= (cell_cur == CELL_FOOD);
          end
          ST_HEAD_WR: begin
            head_x <= next_x;
            head_y <= next_y;
            if (eat) score <= score + 1'b1;
          end
          ST_FOOD_CHK: if (cell_cur != CELL_EMPTY) tries <= tries + 1'b1;
          default: ;
        endcase
      end
    end
  end

  // data registers
  always_ff @(posedge clk) begin
    if (rd_pend) cell_q <= ram_rdata;
    if (state == ST_HEAD_RD && free) begin
      next_x <= step_x;
      next_y <= step_y;
    end
    if (state == ST_HEAD_WR && free) tail_addr <= fifo_tail;
    if (state == ST_FOOD_RD && free) food_addr <= lfsr[ADDR_W-1:0];
  end

  snake_pos_fifo #(
    .DEPTH (MAX_LEN),
    .WIDTH (ADDR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (fifo_clr),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .tail  (fifo_tail),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_snake_grid_sched.sv
// tb_snake_grid_sched: directed bench for snake_grid_sched with a behavioural
// single-port grid RAM. Follows WALL_DEATH_EN for the edge-wrap expectations.
module tb_snake_grid_sched;

  localparam int N = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [3:0]  mode = 4'd0;
  logic [1:0]  forward = 2'd0;
  logic        disp_req = 1'b0;
  logic [9:0]  disp_addr = '0;
  logic        disp_valid;
  logic [1:0]  disp_rdata;
  logic        ram_ce, ram_we;
  logic [9:0]  ram_addr;
  logic [1:0]  ram_wdata;
  logic [1:0]  ram_rdata = 2'd0;
  logic        busy, dead;
  logic [6:0]  length;
  logic [15:0] score;

  always #5 clk = ~clk;

  snake_grid_sched dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mode       (mode),
    .forward    (forward),
    .disp_req   (disp_req),
    .disp_addr  (disp_addr),
    .disp_valid (disp_valid),
    .disp_rdata (disp_rdata),
    .ram_ce     (ram_ce),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .busy       (busy),
    .dead       (dead),
    .length     (length),
    .score      (score)
  );

  // grid RAM model with write statistics
  logic [1:0] mem [N];
  int         wr_empty = 0, wr_body = 0, wr_food = 0, food_over = 0;
  logic       poke_en = 1'b0, fill_en = 1'b0;
  logic [9:0] poke_addr = '0;
  logic [1:0] poke_val = '0;

  always @(posedge clk) begin
    if (fill_en) for (int i = 0; i < N; i++) mem[i] <= 2'd3;
    if (poke_en) mem[poke_addr] <= poke_val;
    if (ram_ce) begin
      if (ram_we) begin
        mem[ram_addr] <= ram_wdata;
        case (ram_wdata)
          2'd0: wr_empty <= wr_empty + 1;
          2'd1: wr_body  <= wr_body + 1;
          2'd2: begin
            wr_food <= wr_food + 1;
            if (mem[ram_addr] != 2'd0) food_over <= food_over + 1;
          end
          default: ;
        endcase
      end else begin
        ram_rdata <= mem[ram_addr];
      end
    end
  end

  int n_cmp = 0, n_bad = 0;
  int s_empty, s_body, s_food, s_over;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input int a, input logic [1:0] v);
    poke_addr = 10'(a);
    poke_val  = v;
    poke_en   = 1'b1;
    cyc();
    poke_en   = 1'b0;
  endtask

  task automatic tick(input logic [3:0] m, input logic [1:0] f);
    en = 1'b1;
    mode = m;
    forward = f;
    cyc();
    en = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 5000) begin
      cyc();
      n++;
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_timeout: busy=%0b after %0d cycles, want 0", name, busy, n);
    end
  endtask

  task automatic snap();
    s_empty = wr_empty;
    s_body  = wr_body;
    s_food  = wr_food;
    s_over  = food_over;
  endtask

  function automatic int count_code(input logic [1:0] c);
    int k = 0;
    for (int i = 0; i < N; i++) if (mem[i] == c) k++;
    return k;
  endfunction

  // remove all food and put a single piece far from the snake's row
  task automatic reset_food();
    for (int i = 0; i < N; i++) if (mem[i] == 2'd2) poke(i, 2'd0);
    poke(0, 2'd2);
  endtask

  task automatic test_reset();
    fill_en = 1'b1;
    cyc();
    fill_en = 1'b0;
    repeat (3) cyc();
    rst = 1'b0;
    cyc();
    n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_cmp++; if (dead !== 1'b0)       begin n_bad++; $display("FAIL reset_dead: got %0b want 0", dead); end
    n_cmp++; if (length !== 7'd0)     begin n_bad++; $display("FAIL reset_length: got %0d want 0", length); end
    n_cmp++; if (score !== 16'd0)     begin n_bad++; $display("FAIL reset_score: got %0d want 0", score); end
    n_cmp++; if (ram_ce !== 1'b0)     begin n_bad++; $display("FAIL reset_ram_ce: got %0b want 0", ram_ce); end
    n_cmp++; if (disp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_disp_valid: got %0b want 0", disp_valid); end
  endtask

  task automatic test_clear_init();
    snap();
    tick(4'd0, 2'b00);
    wait_idle("t1");
    n_cmp++; if (wr_empty - s_empty != 1024) begin n_bad++; $display("FAIL t1_empty_writes: got %0d want 1024", wr_empty - s_empty); end
    n_cmp++; if (wr_body - s_body != 1)      begin n_bad++; $display("FAIL t1_body_writes: got %0d want 1", wr_body - s_body); end
    n_cmp++; if (wr_food - s_food != 1)      begin n_bad++; $display("FAIL t1_food_writes: got %0d want 1", wr_food - s_food); end
    n_cmp++; if (food_over != s_over)        begin n_bad++; $display("FAIL t1_food_on_used: got %0d want 0", food_over - s_over); end
    n_cmp++; if (mem[528] !== 2'd1)          begin n_bad++; $display("FAIL t1_centre: got %0d want 1", mem[528]); end
    n_cmp++; if (count_code(2'd3) != 0)      begin n_bad++; $display("FAIL t1_rsvd_left: got %0d want 0", count_code(2'd3)); end
    n_cmp++; if (count_code(2'd0) != 1022)   begin n_bad++; $display("FAIL t1_empty_cells: got %0d want 1022", count_code(2'd0)); end
    n_cmp++; if (length !== 7'd1)            begin n_bad++; $display("FAIL t1_length: got %0d want 1", length); end
    n_cmp++; if (score !== 16'd0)            begin n_bad++; $display("FAIL t1_score: got %0d want 0", score); end
  endtask

  task automatic test_move();
    reset_food();
    snap();
    tick(4'd1, 2'b00);
    wait_idle("t2");
    n_cmp++; if (mem[529] !== 2'd1)     begin n_bad++; $display("FAIL t2_new_head: got %0d want 1", mem[529]); end
    n_cmp++; if (mem[528] !== 2'd0)     begin n_bad++; $display("FAIL t2_old_tail: got %0d want 0", mem[528]); end
    n_cmp++; if (length !== 7'd1)       begin n_bad++; $display("FAIL t2_length: got %0d want 1", length); end
    n_cmp++; if (wr_food != s_food)     begin n_bad++; $display("FAIL t2_food_writes: got %0d want 0", wr_food - s_food); end
    n_cmp++; if (mem[0] !== 2'd2)       begin n_bad++; $display("FAIL t2_food_kept: got %0d want 2", mem[0]); end
  endtask

  task automatic test_eat();
    poke(530, 2'd2);
    snap();
    tick(4'd1, 2'b00);
    wait_idle("t3");
    n_cmp++; if (score !== 16'd1)          begin n_bad++; $display("FAIL t3_score: got %0d want 1", score); end
    n_cmp++; if (length !== 7'd2)          begin n_bad++; $display("FAIL t3_length: got %0d want 2", length); end
    n_cmp++; if (mem[529] !== 2'd1 || mem[530] !== 2'd1) begin n_bad++; $display("FAIL t3_body: got %0d,%0d want 1,1", mem[529], mem[530]); end
    n_cmp++; if (wr_empty != s_empty)      begin n_bad++; $display("FAIL t3_tail_clear: got %0d want 0", wr_empty - s_empty); end
    n_cmp++; if (wr_food - s_food != 1)    begin n_bad++; $display("FAIL t3_food_writes: got %0d want 1", wr_food - s_food); end
    n_cmp++; if (food_over != s_over)      begin n_bad++; $display("FAIL t3_food_on_used: got %0d want 0", food_over - s_over); end
    n_cmp++; if (count_code(2'd2) != 2)    begin n_bad++; $display("FAIL t3_food_cells: got %0d want 2", count_code(2'd2)); end
  endtask

  task automatic test_disp_stall();
    logic [9:0] a;
    reset_food();
    tick(4'd1, 2'b00);
    cyc();
    disp_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a = 10'(520 + i);
      disp_addr = a;
      #1;
      n_cmp++; if (ram_ce !== 1'b1 || ram_we !== 1'b0 || ram_addr !== a) begin n_bad++; $display("FAIL t4_port_%0d: ce=%0b we=%0b addr=%0d want 1,0,%0d", i, ram_ce, ram_we, ram_addr, a); end
      cyc();
      n_cmp++; if (disp_valid !== 1'b1 || disp_rdata !== mem[a]) begin n_bad++; $display("FAIL t4_disp_%0d: valid=%0b data=%0d want 1,%0d", i, disp_valid, disp_rdata, mem[a]); end
    end
    disp_req = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL t4_stalled: busy=%0b want 1", busy); end
    cyc();
    n_cmp++; if (disp_valid !== 1'b0) begin n_bad++; $display("FAIL t4_valid_drop: got %0b want 0", disp_valid); end
    wait_idle("t4");
    n_cmp++; if (mem[529] !== 2'd0 || mem[530] !== 2'd1 || mem[531] !== 2'd1) begin n_bad++; $display("FAIL t4_final: got %0d,%0d,%0d want 0,1,1", mem[529], mem[530], mem[531]); end
    n_cmp++; if (length !== 7'd2) begin n_bad++; $display("FAIL t4_length: got %0d want 2", length); end
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 12; k++) begin
      tick(4'd1, 2'b00);
      wait_idle("t5_walk");
    end
    n_cmp++; if (mem[542] !== 2'd1 || mem[543] !== 2'd1) begin n_bad++; $display("FAIL t5_at_edge: got %0d,%0d want 1,1", mem[542], mem[543]); end
    tick(4'd1, 2'b00);
    wait_idle("t5");
`ifdef WALL_DEATH_EN
    n_cmp++; if (dead !== 1'b1)     begin n_bad++; $display("FAIL t5_wall_dead: got %0b want 1", dead); end
    n_cmp++; if (mem[512] !== 2'd0) begin n_bad++; $display("FAIL t5_no_write: got %0d want 0", mem[512]); end
    n_cmp++; if (mem[542] !== 2'd1) begin n_bad++; $display("FAIL t5_tail_kept: got %0d want 1", mem[542]); end
`else
    n_cmp++; if (dead !== 1'b0)     begin n_bad++; $display("FAIL t5_wrap_dead: got %0b want 0", dead); end
    n_cmp++; if (mem[512] !== 2'd1) begin n_bad++; $display("FAIL t5_wrap_head: got %0d want 1", mem[512]); end
    n_cmp++; if (mem[542] !== 2'd0) begin n_bad++; $display("FAIL t5_wrap_tail: got %0d want 0", mem[542]); end
`endif
  endtask

  task automatic test_collision();
    tick(4'd0, 2'b00);
    wait_idle("t6_reset");
    n_cmp++; if (dead !== 1'b0 || length !== 7'd1) begin n_bad++; $display("FAIL t6_fresh: dead=%0b len=%0d want 0,1", dead, length); end
    poke(529, 2'd1);
    snap();
    tick(4'd1, 2'b00);
    wait_idle("t6");
    n_cmp++; if (dead !== 1'b1)      begin n_bad++; $display("FAIL t6_dead: got %0b want 1", dead); end
    n_cmp++; if (wr_body != s_body)  begin n_bad++; $display("FAIL t6_no_write: got %0d want 0", wr_body - s_body); end
    n_cmp++; if (mem[528] !== 2'd1)  begin n_bad++; $display("FAIL t6_head_kept: got %0d want 1", mem[528]); end
    tick(4'd1, 2'b00);
    n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL t6_ignored: busy=%0b want 0", busy); end
    tick(4'd0, 2'b00);
    wait_idle("t6_revive");
    n_cmp++; if (dead !== 1'b0 || length !== 7'd1 || score !== 16'd0) begin n_bad++; $display("FAIL t6_revive: dead=%0b len=%0d score=%0d want 0,1,0", dead, length, score); end
  endtask

  task automatic test_tail_collision();
    poke(529, 2'd2);
    tick(4'd1, 2'b00);
    wait_idle("tail_eat");
    n_cmp++; if (length !== 7'd2) begin n_bad++; $display("FAIL tail_grow: got %0d want 2", length); end
    tick(4'd1, 2'b01);
    wait_idle("tail");
    n_cmp++; if (dead !== 1'b1 || mem[528] !== 2'd1) begin n_bad++; $display("FAIL tail_dead: dead=%0b cell=%0d want 1,1", dead, mem[528]); end
  endtask

  task automatic test_preempt();
    snap();
    tick(4'd0, 2'b00);
    repeat (10) cyc();
    tick(4'd1, 2'b00);
    repeat (3) cyc();
    tick(4'd0, 2'b00);
    wait_idle("preempt");
    n_cmp++; if (wr_empty - s_empty != 1039) begin n_bad++; $display("FAIL preempt_empty_writes: got %0d want 1039", wr_empty - s_empty); end
    n_cmp++; if (wr_body - s_body != 1)      begin n_bad++; $display("FAIL preempt_body_writes: got %0d want 1", wr_body - s_body); end
    n_cmp++; if (dead !== 1'b0 || length !== 7'd1) begin n_bad++; $display("FAIL preempt_state: dead=%0b len=%0d want 0,1", dead, length); end
  endtask

  initial begin
    test_reset();
    test_clear_init();
    test_move();
    test_eat();
    test_disp_stall();
    test_wrap();
    test_collision();
    test_tail_collision();
    test_preempt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
